// File: rtl/axi4_types_pkg.sv
// Shared AXI4 response encodings, size codes and the size/alignment helper
// used by the SRAM slave.
package axi4_types;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi4_resp_el;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  // Only byte/half/word transfers exist on this port; wider sizes are errors.
  function automatic logic size_align_ok(input logic [2:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      AXI_SIZE_BYTE: ok = 1'b1;
      AXI_SIZE_HALF: ok = ~lsb[0];
      AXI_SIZE_WORD: ok = (lsb == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi4_sram_slave_sram_dp.sv
// Dual-port SRAM: one byte-enabled write port, one registered read port.
// A same-edge read and write to one word returns the old contents.
module sram_dp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    waddr_i,
  input  logic [DATA_W/8-1:0] wbe_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we_i && wbe_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 slave in front of sram_dp. Independent write (AW/W/B) and
// read (AR/R) state machines; illegal accesses answer SLVERR without touching memory.
module axi4_sram_slave
  import axi4_types::*;
#(
  parameter int                    WORD_SIZE   = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [WORD_SIZE-1:0]  BASE_ADDR   = '0
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [WORD_SIZE-1:0]   AWADDR,
  input  logic [2:0]             AWSIZE,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [WORD_SIZE-1:0]   WDATA,
  input  logic [WORD_SIZE/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [WORD_SIZE-1:0]   ARADDR,
  input  logic [2:0]             ARSIZE,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [WORD_SIZE-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY
);

  localparam int                   IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [WORD_SIZE-1:0] WINDOW = WORD_SIZE'(DEPTH_WORDS * 4);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_MEM  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  // Handshakes: a transfer happens on the ACLK edge where VALID and READY are
  // both high; VALID and its payload never change until that edge.

  logic [WORD_SIZE-1:0] aw_off, ar_off;
  logic                 aw_legal, ar_legal;
  logic [IDX_W-1:0]     aw_idx, ar_idx;

  assign aw_off   = AWADDR - BASE_ADDR;
  assign ar_off   = ARADDR - BASE_ADDR;
  assign aw_legal = (aw_off < WINDOW) && size_align_ok(AWSIZE, AWADDR[1:0]);
  assign ar_legal = (ar_off < WINDOW) && size_align_ok(ARSIZE, ARADDR[1:0]);
  assign aw_idx   = aw_off[IDX_W+1:2];
  assign ar_idx   = ar_off[IDX_W+1:2];

  logic [1:0]       w_state_q, w_state_d;
  logic             aw_ready_q, aw_ready_d;
  logic             w_ready_q, w_ready_d;
  logic             b_valid_q, b_valid_d;
  axi4_resp_el      bresp_q, bresp_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic             w_legal_q, w_legal_d;
  logic             mem_we;

  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    bresp_d    = bresp_q;
    w_idx_d    = w_idx_q;
    w_legal_d  = w_legal_q;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_ready_q && AWVALID) begin
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          w_idx_d    = aw_idx;
          w_legal_d  = aw_legal;
          w_state_d  = W_DATA;
        end else begin
          aw_ready_d = 1'b1;
        end
      end
      W_DATA: begin
        if (w_ready_q && WVALID) begin
          w_ready_d = 1'b0;
          b_valid_d = 1'b1;
          bresp_d   = w_legal_q ? OKAY : SLVERR;
          mem_we    = w_legal_q;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_valid_q && BREADY) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      bresp_q    <= OKAY;
      w_idx_q    <= '0;
      w_legal_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      bresp_q    <= bresp_d;
      w_idx_q    <= w_idx_d;
      w_legal_q  <= w_legal_d;
    end
  end

  logic [1:0]           r_state_q, r_state_d;
  logic                 ar_ready_q, ar_ready_d;
  logic                 r_valid_q, r_valid_d;
  axi4_resp_el          rresp_q, rresp_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 r_legal_q, r_legal_d;
  logic                 mem_re;
  logic [WORD_SIZE-1:0] mem_rdata;

  // The SRAM is read on the AR handshake edge itself; R_MEM is the cycle the
  // array output settles before it is captured into the R payload register.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    r_legal_d  = r_legal_q;
    mem_re     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_ready_q && ARVALID) begin
          ar_ready_d = 1'b0;
          r_legal_d  = ar_legal;
          mem_re     = 1'b1;
          r_state_d  = R_MEM;
        end else begin
          ar_ready_d = 1'b1;
        end
      end
      R_MEM: begin
        r_valid_d = 1'b1;
        rdata_d   = r_legal_q ? mem_rdata : '0;
        rresp_d   = r_legal_q ? OKAY : SLVERR;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (r_valid_q && RREADY) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          r_state_d  = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      r_legal_q  <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      r_legal_q  <= r_legal_d;
    end
  end

  sram_dp #(
    .DATA_W (WORD_SIZE),
    .DEPTH  (DEPTH_WORDS),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk_i   (ACLK),
    .we_i    (mem_we & ~ARESET),
    .waddr_i (w_idx_q),
    .wbe_i   (WSTRB),
    .wdata_i (WDATA),
    .re_i    (mem_re & ~ARESET),
    .raddr_i (ar_idx),
    .rdata_o (mem_rdata)
  );

  assign AWREADY = aw_ready_q;
  assign WREADY  = w_ready_q;
  assign BVALID  = b_valid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = ar_ready_q;
  assign RVALID  = r_valid_q;
  assign RLAST   = r_valid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: writes/reads with hand-computed results,
// error responses, back-pressure, read/write collision and mid-transaction reset.
module tb_axi4_sram_slave;

  logic        ACLK, ARESET;
  logic [31:0] AWADDR;
  logic [2:0]  AWSIZE;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  int n_vec = 0;
  int n_err = 0;

  axi4_sram_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end on a negedge of ACLK.
  task automatic aw_send(input logic [31:0] a, input logic [2:0] s);
    int n = 0;
    AWADDR = a; AWSIZE = s; AWVALID = 1'b1;
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("awready", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb);
    int n = 0;
    WDATA = d; WSTRB = strb; WVALID = 1'b1;
    while (!WREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("wready", 32'(WREADY), 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic b_take(input int hold, input logic [1:0] exp_resp);
    int n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    chk("bvalid", 32'(BVALID), 32'd1);
    chk("bresp", 32'(BRESP), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 32'(BVALID), 32'd1);
      chk("bresp_hold", 32'(BRESP), 32'(exp_resp));
      chk("awready_hold", 32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_drop", 32'(BVALID), 32'd0);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [2:0] s);
    int n = 0;
    ARADDR = a; ARSIZE = s; ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("arready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  // Entered on the first negedge after the AR handshake edge.
  task automatic r_take(input int hold, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int lat = 1;
    while (!RVALID && lat < 20) begin @(negedge ACLK); lat++; end
    chk("r_latency", 32'(lat), 32'd2);
    chk("rdata", RDATA, exp_d);
    chk("rresp", 32'(RRESP), 32'(exp_r));
    chk("rlast", 32'(RLAST), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk("rvalid_hold", 32'(RVALID), 32'd1);
      chk("rdata_hold", RDATA, exp_d);
      chk("rresp_hold", 32'(RRESP), 32'(exp_r));
      chk("arready_hold", 32'(ARREADY), 32'd0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("rvalid_drop", 32'(RVALID), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                    input logic [3:0] strb, input logic [1:0] exp_resp);
    aw_send(a, s);
    w_send(d, strb);
    b_take(0, exp_resp);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    ar_send(a, 3'd2);
    r_take(0, exp_d, exp_r);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, 32'(AWREADY), 32'd0);
    chk({tag, "_wready"},  32'(WREADY),  32'd0);
    chk({tag, "_arready"}, 32'(ARREADY), 32'd0);
    chk({tag, "_bvalid"},  32'(BVALID),  32'd0);
    chk({tag, "_rvalid"},  32'(RVALID),  32'd0);
    chk({tag, "_bresp"},   32'(BRESP),   32'd0);
    chk({tag, "_rresp"},   32'(RRESP),   32'd0);
    chk({tag, "_rdata"},   RDATA,        32'd0);
    chk({tag, "_rlast"},   32'(RLAST),   32'd0);
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_idle_outputs("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("awready_after_reset", 32'(AWREADY), 32'd1);
    chk("arready_after_reset", 32'(ARREADY), 32'd1);

    // Basic word store and load
    wr(32'h10, 3'd2, 32'hDEADBEEF, 4'b1111, OK);
    rd(32'h10, 32'hDEADBEEF, OK);

    // Single byte lane merge
    wr(32'h20, 3'd2, 32'h11223344, 4'b1111, OK);
    wr(32'h20, 3'd0, 32'h0000AA00, 4'b0010, OK);
    rd(32'h20, 32'h1122AA44, OK);

    // Zero strobe leaves memory alone but answers OKAY
    wr(32'h20, 3'd2, 32'hFFFFFFFF, 4'b0000, OK);
    rd(32'h20, 32'h1122AA44, OK);

    // Half-word store on upper lanes
    wr(32'h22, 3'd1, 32'h55660000, 4'b1100, OK);
    rd(32'h20, 32'h5566AA44, OK);

    // Illegal writes: misaligned, out of window (would alias word 0), bad size
    wr(32'h0, 3'd2, 32'h0BADC0DE, 4'b1111, OK);
    wr(32'h12, 3'd2, 32'hCAFEF00D, 4'b1111, SE);
    rd(32'h10, 32'hDEADBEEF, OK);
    wr(32'h1000, 3'd2, 32'h12345678, 4'b1111, SE);
    rd(32'h0, 32'h0BADC0DE, OK);
    wr(32'h21, 3'd1, 32'h0000FFFF, 4'b0011, SE);
    wr(32'h10, 3'd3, 32'h0, 4'b1111, SE);
    rd(32'h20, 32'h5566AA44, OK);
    rd(32'h10, 32'hDEADBEEF, OK);

    // Illegal reads
    rd(32'h1000, 32'h0, SE);
    ar_send(32'h12, 3'd2);
    r_take(0, 32'h0, SE);
    ar_send(32'h11, 3'd0);
    r_take(0, 32'hDEADBEEF, OK);

    // Back-pressure on B and R
    aw_send(32'h30, 3'd2);
    w_send(32'hA5A5_5A5A, 4'b1111);
    b_take(5, OK);
    ar_send(32'h30, 3'd2);
    r_take(5, 32'hA5A5_5A5A, OK);

    // Same-edge commit and read of one word returns the old word
    wr(32'h40, 3'd2, 32'h1, 4'b1111, OK);
    aw_send(32'h40, 3'd2);
    WDATA = 32'h2; WSTRB = 4'b1111; WVALID = 1'b1;
    ARADDR = 32'h40; ARSIZE = 3'd2; ARVALID = 1'b1;
    chk("col_wready", 32'(WREADY), 32'd1);
    chk("col_arready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0; ARVALID = 1'b0;
    r_take(0, 32'h1, OK);
    b_take(0, OK);
    rd(32'h40, 32'h2, OK);

    // Reset while in W_DATA, with the data beat presented on the reset edge
    wr(32'h50, 3'd2, 32'h5555AAAA, 4'b1111, OK);
    aw_send(32'h50, 3'd2);
    ARESET = 1'b1; WDATA = 32'h99999999; WSTRB = 4'b1111; WVALID = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0; WVALID = 1'b0;
    chk_idle_outputs("wreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("wreset_no_bvalid", 32'(BVALID), 32'd0);
    end
    chk("wreset_awready", 32'(AWREADY), 32'd1);
    rd(32'h50, 32'h5555AAAA, OK);
    wr(32'h50, 3'd2, 32'h12345678, 4'b1111, OK);
    rd(32'h50, 32'h12345678, OK);

    // Reset while in R_MEM
    ar_send(32'h10, 3'd2);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    chk_idle_outputs("rreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("rreset_no_rvalid", 32'(RVALID), 32'd0);
    end
    chk("rreset_arready", 32'(ARREADY), 32'd1);
    rd(32'h10, 32'hDEADBEEF, OK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
